// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - Game of Life rule constants and neighbour popcount helper.
package life_pkg;

    localparam int NEIGHBOR_COUNT_WIDTH = 4;
    localparam int BANK_COUNT           = 9;

    localparam logic [NEIGHBOR_COUNT_WIDTH-1:0] LIFE_BIRTH      = 4'd3;
    localparam logic [NEIGHBOR_COUNT_WIDTH-1:0] LIFE_SURVIVE_LO = 4'd2;
    localparam logic [NEIGHBOR_COUNT_WIDTH-1:0] LIFE_SURVIVE_HI = 4'd3;

    function automatic logic [NEIGHBOR_COUNT_WIDTH-1:0] popcount9(input logic [BANK_COUNT-1:0] v);
        logic [NEIGHBOR_COUNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < BANK_COUNT; i++) begin
            cnt = cnt + {{(NEIGHBOR_COUNT_WIDTH-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// rtl/pipe_delay.sv - Fixed-depth shift register with asynchronous active-high clear.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/life_next_state.sv
// rtl/life_next_state.sv - Life rule on nine interleaved bank reads; population tracking under LIFE_POPULATION_EN.
module life_next_state
    import life_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 1,
    parameter int GEN_WIDTH    = 16,
    parameter int POP_WIDTH    = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [BANK_COUNT-1:0] in_center,
    input  logic [BANK_COUNT-1:0] in_mask,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_last,
    input  logic [BANK_COUNT-1:0] rd_data,
    output logic                  out_wr_valid,
    output logic [BANK_COUNT-1:0] out_wr_enable,
    output logic [ADDR_WIDTH-1:0] out_wr_addr,
    output logic                  out_wr_data,
    output logic                  gen_done,
    output logic [GEN_WIDTH-1:0]  generation,
    output logic [POP_WIDTH-1:0]  population
);

    localparam int CTRL_WIDTH = 2 * BANK_COUNT + ADDR_WIDTH + 2;

    logic [CTRL_WIDTH-1:0] ctrl_in, ctrl_d;
    logic                  valid_d, last_d;
    logic [BANK_COUNT-1:0] center_d, mask_d;
    logic [ADDR_WIDTH-1:0] addr_d;

    assign ctrl_in = {in_valid, in_last, in_center, in_mask, in_addr};

    // Control rides alongside the RAM reads so it lines up with rd_data.
    pipe_delay #(
        .WIDTH (CTRL_WIDTH),
        .DEPTH (READ_LATENCY)
    ) u_align (
        .clk (clk),
        .rst (reset),
        .d   (ctrl_in),
        .q   (ctrl_d)
    );

    assign {valid_d, last_d, center_d, mask_d, addr_d} = ctrl_d;

    logic [BANK_COUNT-1:0]           live;
    logic                            centre_live;
    logic [NEIGHBOR_COUNT_WIDTH-1:0] count;

    assign live        = rd_data & mask_d;
    assign centre_live = |(live & center_d);
    assign count       = popcount9(live & ~center_d);

    logic                            valid_s1, last_s1, centre_s1;
    logic [BANK_COUNT-1:0]           center_s1;
    logic [ADDR_WIDTH-1:0]           addr_s1;
    logic [NEIGHBOR_COUNT_WIDTH-1:0] count_s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_s1  <= 1'b0;
            last_s1   <= 1'b0;
            centre_s1 <= 1'b0;
            center_s1 <= '0;
            addr_s1   <= '0;
            count_s1  <= '0;
        end else begin
            valid_s1  <= valid_d;
            last_s1   <= valid_d & last_d;
            centre_s1 <= centre_live;
            center_s1 <= center_d;
            addr_s1   <= addr_d;
            count_s1  <= count;
        end
    end

    logic next_state;
    logic last_s2;

    assign next_state = (count_s1 == LIFE_BIRTH) |
                        (centre_s1 & (count_s1 >= LIFE_SURVIVE_LO) & (count_s1 <= LIFE_SURVIVE_HI));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_wr_valid  <= 1'b0;
            out_wr_enable <= '0;
            out_wr_addr   <= '0;
            out_wr_data   <= 1'b0;
            last_s2       <= 1'b0;
        end else begin
            out_wr_valid  <= valid_s1;
            out_wr_enable <= center_s1 & {BANK_COUNT{valid_s1}};
            out_wr_addr   <= addr_s1;
            out_wr_data   <= next_state & valid_s1;
            last_s2       <= last_s1;
        end
    end

    logic frame_end;
    assign frame_end = out_wr_valid & last_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_done   <= 1'b0;
            generation <= '0;
        end else begin
            gen_done <= frame_end;
            if (frame_end) begin
                generation <= generation + GEN_WIDTH'(1);
            end
        end
    end

`ifdef LIFE_POPULATION_EN
    logic [POP_WIDTH-1:0] pop_acc;
    logic [POP_WIDTH-1:0] pop_sum;

    // Writes with an all-zero enable land nowhere, so they never count as live.
    assign pop_sum = pop_acc + {{(POP_WIDTH-1){1'b0}}, out_wr_valid & (|out_wr_enable) & out_wr_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_acc    <= '0;
            population <= '0;
        end else if (frame_end) begin
            pop_acc    <= '0;
            population <= pop_sum;
        end else begin
            pop_acc    <= pop_sum;
        end
    end
`else
    assign population = '0;
`endif

endmodule

// File: tb/tb_life_next_state.sv
// tb/tb_life_next_state.sv - Scoreboard bench for life_next_state with READ_LATENCY=2.
module tb_life_next_state;

    localparam int AW = 4;
    localparam int L  = 2;
    localparam int GW = 16;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [8:0]    in_center;
    logic [8:0]    in_mask;
    logic [AW-1:0] in_addr;
    logic          in_last;
    logic [8:0]    rd_data;
    logic          out_wr_valid;
    logic [8:0]    out_wr_enable;
    logic [AW-1:0] out_wr_addr;
    logic          out_wr_data;
    logic          gen_done;
    logic [GW-1:0] generation;
    logic [PW-1:0] population;

    life_next_state #(
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (L),
        .GEN_WIDTH    (GW),
        .POP_WIDTH    (PW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_center     (in_center),
        .in_mask       (in_mask),
        .in_addr       (in_addr),
        .in_last       (in_last),
        .rd_data       (rd_data),
        .out_wr_valid  (out_wr_valid),
        .out_wr_enable (out_wr_enable),
        .out_wr_addr   (out_wr_addr),
        .out_wr_data   (out_wr_data),
        .gen_done      (gen_done),
        .generation    (generation),
        .population    (population)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [8:0]    en;
        logic [AW-1:0] addr;
        logic          data;
    } wr_t;

    typedef struct {
        int at;
        int gen;
        int pop;
    } gd_t;

    wr_t  wq[$];
    gd_t  gq[$];
    int   total = 0;
    int   bad = 0;
    int   model_gen = 0;
    int   model_pop = 0;
    logic mon_en = 1'b0;
    logic [8:0] rd_hist [L+1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rule(input logic [8:0] c, input logic [8:0] m, input logic [8:0] rd);
        int   n = 0;
        logic alive = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (m[i] && rd[i]) begin
                if (c[i]) alive = 1'b1;
                else n++;
            end
        end
        return (n == 3) || (alive && n == 2);
    endfunction

    task automatic drive(input logic v, input logic [8:0] c, input logic [8:0] m,
                         input logic [AW-1:0] a, input logic l, input logic [8:0] rd);
        wr_t w;
        gd_t g;
        @(negedge clk);
        in_valid  = v;
        in_center = c;
        in_mask   = m;
        in_addr   = a;
        in_last   = l;
        for (int k = L; k > 0; k--) rd_hist[k] = rd_hist[k-1];
        rd_hist[0] = rd;
        rd_data = rd_hist[L];
        if (v) begin
            w.at   = cyc + L + 2;
            w.en   = c;
            w.addr = a;
            w.data = rule(c, m, rd);
            wq.push_back(w);
            if (c != 9'h000 && w.data) model_pop++;
            if (l) begin
                model_gen++;
                g.at  = cyc + L + 3;
                g.gen = model_gen;
`ifdef LIFE_POPULATION_EN
                g.pop = model_pop;
`else
                g.pop = 0;
`endif
                gq.push_back(g);
                model_pop = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 9'h000, 9'h000, '0, 1'b0, 9'h000);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, {31'b0, out_wr_valid}, 32'd0);
        check({tag, "_enable"}, {23'b0, out_wr_enable}, 32'd0);
        check({tag, "_data"}, {31'b0, out_wr_data}, 32'd0);
        check({tag, "_gen_done"}, {31'b0, gen_done}, 32'd0);
        check({tag, "_generation"}, {16'b0, generation}, 32'd0);
        check({tag, "_population"}, {26'b0, population}, 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && reset === 1'b0) begin
            if (wq.size() > 0 && wq[0].at == cyc) begin
                check("wr_valid", {31'b0, out_wr_valid}, 32'd1);
                check("wr_enable", {23'b0, out_wr_enable}, {23'b0, wq[0].en});
                check("wr_addr", {28'b0, out_wr_addr}, {28'b0, wq[0].addr});
                check("wr_data", {31'b0, out_wr_data}, {31'b0, wq[0].data});
                void'(wq.pop_front());
            end else if (out_wr_valid !== 1'b0 || out_wr_enable !== 9'h000) begin
                check("wr_unexpected", {31'b0, out_wr_valid}, 32'd0);
            end
            if (gq.size() > 0 && gq[0].at == cyc) begin
                check("gen_done", {31'b0, gen_done}, 32'd1);
                check("generation", {16'b0, generation}, gq[0].gen);
                check("population", {26'b0, population}, gq[0].pop);
                void'(gq.pop_front());
            end else if (gen_done !== 1'b0) begin
                check("gen_done_unexpected", {31'b0, gen_done}, 32'd0);
            end
        end
    end

    initial begin
        logic [8:0] r;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_center = '0;
        in_mask   = '0;
        in_addr   = '0;
        in_last   = 1'b0;
        rd_data   = '0;
        for (int k = 0; k <= L; k++) rd_hist[k] = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        reset  = 1'b0;
        mon_en = 1'b1;

        drive(1'b1, 9'h010, 9'h1FF, 4'h3, 1'b0, 9'h007);
        drive(1'b1, 9'h010, 9'h1FF, 4'h4, 1'b0, 9'h013);
        drive(1'b1, 9'h010, 9'h1FF, 4'h5, 1'b0, 9'h017);
        drive(1'b1, 9'h010, 9'h1FF, 4'h6, 1'b0, 9'h011);
        drive(1'b1, 9'h010, 9'h1FF, 4'h7, 1'b0, 9'h01F);
        drive(1'b1, 9'h001, 9'h01B, 4'h8, 1'b0, 9'h1FF);
        drive(1'b1, 9'h001, 9'h003, 4'h9, 1'b0, 9'h1FF);
        drive(1'b1, 9'h000, 9'h1FF, 4'hA, 1'b0, 9'h007);
        idle(6);

        drive(1'b1, 9'h010, 9'h1FF, 4'h5, 1'b1, 9'h007);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        wq.delete();
        gq.delete();
        model_pop = 0;
        model_gen = 0;
        #1;
        check_quiet("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        idle(8);

        for (int i = 0; i < 36; i++) begin
            int b;
            b = i % 9;
            r = '0;
            if (i % 7 == 0 && i < 35) begin
                for (int k = 1; k <= 3; k++) r[(b + k) % 9] = 1'b1;
            end
            drive(1'b1, 9'(1 << b), 9'h1FF, AW'(i % 16), i == 35, r);
        end
        idle(3);

        drive(1'b1, 9'h004, 9'h1FF, 4'h1, 1'b1, 9'h038);
        drive(1'b1, 9'h004, 9'h1FF, 4'h2, 1'b1, 9'h000);
        idle(2);

        for (int i = 0; i < 20 && (wq.size() + gq.size()) > 0; i++) idle(1);
        check("drain", wq.size() + gq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/life_next_state.md
# life_next_state

Consumes the nine bank reads issued by the memory controller for one cell and applies the Game of Life rule. Produces the single-bank write of the cell's next state into the destination frame buffer. Sits directly downstream of the 3x3-interleaved memory controller and the nine pixel RAMs. Tracks generation count and, optionally, live-cell population.

## Interface
Parameters:
- ADDR_WIDTH, 4: block address width, same as the controller.
- READ_LATENCY, 1: cycles from address issue to rd_data valid; must be ≥1.
- GEN_WIDTH, 16: generation counter width.
- POP_WIDTH, 6: population width; must hold HEIGHT_PIXELS*WIDTH_PIXELS.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  controller issued reads this cycle (controller enable).
- in_center  in  9  one-hot bank holding the centre cell (controller write_enable).
- in_mask  in  9  per-bank in-bounds flags (controller read_enable).
- in_addr  in  ADDR_WIDTH  centre block address (controller write_addr).
- in_last  in  1  qualifies the final cell of a generation; only sampled with in_valid.
- rd_data  in  9  one bit per bank, valid READ_LATENCY cycles after in_valid.
- out_wr_valid  out  1  write strobe to destination buffer.
- out_wr_enable  out  9  one-hot bank select, zero when out_wr_valid=0.
- out_wr_addr  out  ADDR_WIDTH  write block address.
- out_wr_data  out  1  next cell state.
- gen_done  out  1  single-cycle pulse after the last write of a generation.
- generation  out  GEN_WIDTH  completed generations.
- population  out  POP_WIDTH  live cells in last completed generation (macro-gated).

## Operation
- Control (in_valid, in_center, in_mask, in_addr, in_last) is delayed READ_LATENCY cycles to align with rd_data.
- Stage 1: live = rd_data & mask_d. Then:
  - centre = |(live & center_d).
  - count = popcount(live & ~center_d), 4 bits, range 0..8.
  - Register count, centre and the aligned control.
- Stage 2: next = (count==3) | (centre & count==2). Register out_wr_* with enable = center_s1 & {9{valid_s1}}.
- Each of the nine window cells lies in a distinct bank, so no reordering is needed.
- Masked-out banks count as dead; this gives the non-toroidal edge.
- in_center all-zero with in_valid: write still strobes with out_wr_enable=0, so no bank is written.
- No backpressure; destination RAM always accepts a write.
- generation increments by 1 (wrapping modulo 2^GEN_WIDTH) on the cycle gen_done is high.

## Timing
- Reset values: all outputs 0; pipeline valids 0; counters 0.
- in_valid at cycle t → out_wr_* valid at t+READ_LATENCY+2.
- Throughput: one cell per cycle, back-to-back, no bubbles.
- gen_done at t_last+READ_LATENCY+3, one cycle after the last write.
- generation and population update in that same cycle.
- Reset asserted mid-stream discards all in-flight cells: no write strobe after reset, even for cells issued before it.
- in_last while a previous generation's gen_done is pending: each last cell produces its own pulse, in order.

## Configuration
- LIFE_POPULATION_EN defined:
  - Accumulator adds out_wr_data on each out_wr_valid with a nonzero enable.
  - On gen_done, the accumulator value including the final write is copied to population, and the accumulator clears.
- Undefined: population is tied to 0 and no accumulator logic exists.

## Structure
- Package life_pkg holds:
  - NEIGHBOR_COUNT_WIDTH=4.
  - Rule constants LIFE_BIRTH=3, LIFE_SURVIVE_LO=2, LIFE_SURVIVE_HI=3.
  - Bank count 9.
- One sub-module, pipe_delay: parameterised width/depth shift register with async reset, used for READ_LATENCY control alignment.

## Test plan
- Birth: centre=9'h010, mask=9'h1FF, rd_data=9'h007 (centre dead) → out_wr_data=1, out_wr_enable=9'h010, addr passed through.
- Survival/death: centre live with 2 neighbours → 1; 3 neighbours → 1; 1 neighbour → 0; 4 neighbours → 0.
- Edge masking: rd_data=9'h1FF, centre=9'h001, mask=9'h01B → count=3, centre live → 1; same with mask=9'h003 → 0.
- Latency: READ_LATENCY=2, in_valid at cycle 10 → out_wr_valid exactly cycle 14; 36 back-to-back cells → 36 consecutive strobes.
- Generation: 36-cell frame yielding 5 live, in_last on cell 36 → gen_done one cycle after final write, generation 0→1, population=5 (macro on) / 0 (off).
- Reset at cycle t+1 after in_valid at t → no out_wr_valid ever appears for that cell; all outputs 0 immediately.
